// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state enums and flag bundle for the sequential ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL,
        OP_SHR, OP_SRA, OP_ROL, OP_MUL, OP_CMP, OP_PASSB
    } opcode_e;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_e;

    typedef struct packed {
        logic cf;
        logic zf;
        logic nf;
        logic vf;
    } flags_t;

endpackage

// File: rtl/alu_mul_unit.sv
// alu_mul_unit: iterative shift-add unsigned multiplier, one partial product per step.
module alu_mul_unit #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               step_i,
    input  logic               last_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    logic [2*WIDTH-1:0] mcand_q, acc_q;
    logic [WIDTH-1:0]   mplier_q;

    // product_o already includes the current step so the caller can capture it on the last edge
    assign product_o = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = step_i & last_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (step_i) begin
            acc_q    <= product_o;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with single-cycle ops, iterative multiply and held result/flags.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [3:0]       OPCODE,
    input  logic [WIDTH-1:0] DATA_A,
    input  logic [WIDTH-1:0] DATA_B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             CF,
    output logic             ZF,
    output logic             NF,
    output logic             VF,
    output logic             ERR,
    output logic             BUSY
);

    localparam int SW = $clog2(WIDTH);

    state_e             state_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q, res_d;
    logic [SW-1:0]      cnt_q, sh, rot;
    flags_t             flg_q, flg_d;
    logic               err_q, err_d, out_valid_q, busy_q, in_ready_q;
    logic [WIDTH:0]     sum_w, dif_w, shl_w, shr_w, sra_w;
    logic [WIDTH-1:0]   rol_w;
    logic               vf_add, vf_sub, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    alu_mul_unit #(.WIDTH(WIDTH)) u_mul (
        .clk      (CLK),
        .rst_n    (RST_N),
        .start_i  (state_q == S_IDLE && IN_VALID),
        .step_i   (state_q == S_MUL),
        .last_i   (cnt_q == SW'(WIDTH - 1)),
        .a_i      (DATA_A),
        .b_i      (DATA_B),
        .done_o   (mul_done),
        .product_o(mul_prod)
    );

    assign sh     = b_q[SW-1:0];
    assign rot    = SW'(32'(sh) % WIDTH);
    assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
    assign dif_w  = {1'b0, a_q} - {1'b0, b_q};
    assign vf_add = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
    assign vf_sub = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_w[WIDTH-1] != a_q[WIDTH-1]);
    // one guard bit on the far side of each shift captures the last bit shifted out
    assign shl_w  = {1'b0, a_q} << sh;
    assign shr_w  = {a_q, 1'b0} >> sh;
    assign sra_w  = $signed({a_q, 1'b0}) >>> sh;
    assign rol_w  = (a_q << rot) | (a_q >> (WIDTH - 32'(rot)));

    always_comb begin
        res_d = '0;
        flg_d = '0;
        err_d = 1'b0;
        case (op_q)
            OP_ADD:   begin res_d = sum_w[WIDTH-1:0]; flg_d.cf = sum_w[WIDTH]; flg_d.vf = vf_add; end
            OP_SUB:   begin res_d = dif_w[WIDTH-1:0]; flg_d.cf = dif_w[WIDTH]; flg_d.vf = vf_sub; end
            OP_AND:   res_d = a_q & b_q;
            OP_OR:    res_d = a_q | b_q;
            OP_XOR:   res_d = a_q ^ b_q;
            OP_NOT:   res_d = ~a_q;
            OP_SHL:   begin res_d = shl_w[WIDTH-1:0]; flg_d.cf = shl_w[WIDTH]; end
            OP_SHR:   begin res_d = shr_w[WIDTH:1]; flg_d.cf = shr_w[0]; end
            OP_SRA:   begin res_d = sra_w[WIDTH:1]; flg_d.cf = sra_w[0]; end
            OP_ROL:   begin res_d = rol_w; flg_d.cf = (sh != '0) && rol_w[0]; end
            OP_MUL:   res_d = '0;
            OP_CMP:   begin res_d = a_q; flg_d.cf = dif_w[WIDTH]; flg_d.vf = vf_sub; end
            OP_PASSB: res_d = b_q;
            default:  err_d = 1'b1;
        endcase
        flg_d.zf = (op_q == OP_CMP) ? (dif_w[WIDTH-1:0] == '0) : (res_d == '0);
        flg_d.nf = (op_q == OP_CMP) ? dif_w[WIDTH-1] : res_d[WIDTH-1];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            flg_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (IN_VALID) begin
                    op_q       <= OPCODE;
                    a_q        <= DATA_A;
                    b_q        <= DATA_B;
                    cnt_q      <= '0;
                    busy_q     <= 1'b1;
                    in_ready_q <= 1'b0;
                    state_q    <= (OPCODE == OP_MUL) ? S_MUL : S_EXEC;
                end
                S_EXEC: begin
                    res_q       <= res_d;
                    flg_q       <= flg_d;
                    err_q       <= err_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_MUL: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mul_done) begin
                        res_q       <= mul_prod[WIDTH-1:0];
                        flg_q       <= '{cf: |mul_prod[2*WIDTH-1:WIDTH], zf: mul_prod[WIDTH-1:0] == '0,
                                         nf: mul_prod[WIDTH-1], vf: 1'b0};
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: if (OUT_READY) begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign BUSY      = busy_q;
    assign RESULT    = res_q;
    assign CF        = flg_q.cf;
    assign ZF        = flg_q.zf;
    assign NF        = flg_q.nf;
    assign VF        = flg_q.vf;
    assign ERR       = err_q;

endmodule
